// File: rtl/lamp_sequence_monitor.sv
// Lamp sequence monitor: checks the upstream light code for one-hot encoding,
// legal RED->GREEN->YELLOW order and dwell time, and drives the lamps (flashing YELLOW on fault).
module lamp_sequence_monitor #(
  parameter int MAX_DWELL = 16,
  parameter int BLINK_DIV = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [0:2]       light,
  input  logic             clear_fault,
  output logic [0:2]       lamp_out,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int DW = $clog2(MAX_DWELL + 1);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [1:0] S_INIT  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_FAULT = 2'b10;

  localparam logic [0:2] L_RED    = 3'b100;
  localparam logic [0:2] L_GREEN  = 3'b010;
  localparam logic [0:2] L_YELLOW = 3'b001;
  localparam logic [0:2] L_OFF    = 3'b000;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_ILLEGAL  = 2'b01;
  localparam logic [1:0] FC_SEQUENCE = 2'b10;
  localparam logic [1:0] FC_STUCK    = 2'b11;

  localparam logic [DW-1:0] DWELL_ZERO = DW'(0);
  localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(MAX_DWELL - 1);
  localparam logic [BW-1:0] BLINK_ZERO = BW'(0);
  localparam logic [BW-1:0] BLINK_ONE  = BW'(1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       r_state;
  logic [0:2]       r_last_q;
  logic [DW-1:0]    r_dwell;
  logic [BW-1:0]    r_blink;
  logic [0:2]       r_lamp_out;
  logic             r_fault;
  logic [1:0]       r_fault_code;
  logic [CNT_W-1:0] r_cycle_count;

  logic [1:0]       w_state_nxt;
  logic [0:2]       w_last_q_nxt;
  logic [DW-1:0]    w_dwell_nxt;
  logic [BW-1:0]    w_blink_nxt;
  logic [0:2]       w_lamp_nxt;
  logic             w_fault_nxt;
  logic [1:0]       w_fault_code_nxt;
  logic [CNT_W-1:0] w_cycle_count_nxt;

  logic       w_onehot;
  logic [0:2] w_succ;
  logic       w_same;
  logic       w_illegal;
  logic       w_seq_err;
  logic       w_stuck;
  logic       w_run_fault;

  always_comb begin
    w_succ = L_GREEN;
    case (r_last_q)
      L_RED:    w_succ = L_GREEN;
      L_GREEN:  w_succ = L_YELLOW;
      L_YELLOW: w_succ = L_RED;
      default:  w_succ = L_GREEN;
    endcase
  end

  assign w_onehot    = (light == L_RED) || (light == L_GREEN) || (light == L_YELLOW);
  assign w_same      = (light == r_last_q);
  assign w_illegal   = !w_onehot;
  assign w_seq_err   = w_onehot && !w_same && (light != w_succ);
  assign w_stuck     = w_onehot && w_same && (r_dwell == DWELL_LAST);
  assign w_run_fault = w_illegal || w_seq_err || w_stuck;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = S_INIT;
    case (r_state)
      S_INIT:  w_state_nxt = (light == L_RED) ? S_RUN : S_INIT;
      S_RUN:   w_state_nxt = w_run_fault ? S_FAULT : S_RUN;
      S_FAULT: w_state_nxt = clear_fault ? S_INIT : S_FAULT;
      default: w_state_nxt = S_INIT;
    endcase
  end

  // Next values of the registered outputs and tracking state; fault priority is encoded by if-order.
  always_comb begin
    w_last_q_nxt      = r_last_q;
    w_dwell_nxt       = r_dwell;
    w_blink_nxt       = r_blink;
    w_lamp_nxt        = r_lamp_out;
    w_fault_nxt       = r_fault;
    w_fault_code_nxt  = r_fault_code;
    w_cycle_count_nxt = r_cycle_count;
    case (r_state)
      S_INIT: begin
        w_lamp_nxt       = L_RED;
        w_fault_nxt      = 1'b0;
        w_fault_code_nxt = FC_NONE;
        if (light == L_RED) begin
          w_last_q_nxt = L_RED;
          w_dwell_nxt  = DWELL_ONE;
        end else begin
          w_dwell_nxt  = r_dwell;
        end
      end
      S_RUN: begin
        if (w_run_fault) begin
          w_fault_nxt = 1'b1;
          w_lamp_nxt  = L_YELLOW;
          w_blink_nxt = BLINK_ZERO;
          if (w_illegal) begin
            w_fault_code_nxt = FC_ILLEGAL;
          end else if (w_seq_err) begin
            w_fault_code_nxt = FC_SEQUENCE;
          end else begin
            w_fault_code_nxt = FC_STUCK;
          end
        end else if (w_same) begin
          w_dwell_nxt = r_dwell + DWELL_ONE;
          w_lamp_nxt  = light;
        end else begin
          w_last_q_nxt = light;
          w_dwell_nxt  = DWELL_ONE;
          w_lamp_nxt   = light;
          if (r_last_q == L_YELLOW) begin
            w_cycle_count_nxt = r_cycle_count + CNT_ONE;
          end else begin
            w_cycle_count_nxt = r_cycle_count;
          end
        end
      end
      S_FAULT: begin
        if (clear_fault) begin
          w_lamp_nxt       = L_RED;
          w_fault_nxt      = 1'b0;
          w_fault_code_nxt = FC_NONE;
          w_dwell_nxt      = DWELL_ZERO;
          w_blink_nxt      = BLINK_ZERO;
        end else if (r_blink == BLINK_LAST) begin
          w_blink_nxt = BLINK_ZERO;
          w_lamp_nxt  = (r_lamp_out == L_YELLOW) ? L_OFF : L_YELLOW;
        end else begin
          w_blink_nxt = r_blink + BLINK_ONE;
        end
      end
      default: begin
        w_lamp_nxt       = L_RED;
        w_fault_nxt      = 1'b0;
        w_fault_code_nxt = FC_NONE;
        w_dwell_nxt      = DWELL_ZERO;
        w_blink_nxt      = BLINK_ZERO;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last_q      <= L_RED;
      r_dwell       <= DWELL_ZERO;
      r_blink       <= BLINK_ZERO;
      r_lamp_out    <= L_RED;
      r_fault       <= 1'b0;
      r_fault_code  <= FC_NONE;
      r_cycle_count <= '0;
    end else begin
      r_last_q      <= w_last_q_nxt;
      r_dwell       <= w_dwell_nxt;
      r_blink       <= w_blink_nxt;
      r_lamp_out    <= w_lamp_nxt;
      r_fault       <= w_fault_nxt;
      r_fault_code  <= w_fault_code_nxt;
      r_cycle_count <= w_cycle_count_nxt;
    end
  end

  assign lamp_out    = r_lamp_out;
  assign fault       = r_fault;
  assign fault_code  = r_fault_code;
  assign cycle_count = r_cycle_count;

endmodule
